// File: rtl/alu_issue_ctrl.sv
// Issue/retire sequencer for alu_4bit: register file, operand latch,
// result and flag writeback with a 3-cycle serialized handshake.
module alu_issue_ctrl #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int RW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [RW-1:0]    in_rd,
    input  logic [RW-1:0]    in_rs1,
    input  logic [RW-1:0]    in_rs2,
    input  logic             in_use_imm,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    output logic [3:0]       flags,
    output logic             illegal,
    input  logic             illegal_clr,
    output logic             done,
    input  logic [RW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] rf [NREGS];
    logic [RW-1:0]    rd_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flg_q;
    logic             accept;
    logic             is_cmp;
    logic             is_rsv;
    logic             do_wr;
    logic             do_flg;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_ready & in_valid;

    // 0100 is compare; 0101..0111 are reserved
    assign is_cmp = (alu_opcode == 4'b0100);
    assign is_rsv = (alu_opcode[3:2] == 2'b01) & (alu_opcode[1:0] != 2'b00);
    assign do_wr  = ~is_cmp & ~is_rsv;
    assign do_flg = ~is_rsv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 4'b0000;
            rd_q       <= '0;
            res_q      <= '0;
            flg_q      <= '0;
            flags      <= '0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (accept) begin
                alu_a      <= rf[in_rs1];
                alu_b      <= in_use_imm ? in_imm : rf[in_rs2];
                alu_opcode <= in_opcode;
                rd_q       <= in_rd;
            end
            if (state_q == EXEC) begin
                res_q <= alu_result;
                flg_q <= {alu_zero, alu_carry, alu_overflow, alu_negative};
            end
            if (state_q == WB) begin
                if (do_wr)  rf[rd_q] <= res_q;
                if (do_flg) flags    <= flg_q;
            end
            // a reserved retire outranks a simultaneous clear
            if (state_q == WB && is_rsv) illegal <= 1'b1;
            else if (illegal_clr)        illegal <= 1'b0;
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with an in-bench ALU and
// a register-file/flags reference model.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic       in_use_imm;
    logic [3:0] in_imm;
    logic [3:0] alu_a, alu_b, alu_opcode, alu_result;
    logic       alu_zero, alu_carry, alu_overflow, alu_negative;
    logic [3:0] flags;
    logic       illegal, illegal_clr, done;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] ref_rf [4];
    logic [3:0] ref_flags;
    logic       ref_ill;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(4), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative),
        .flags(flags), .illegal(illegal), .illegal_clr(illegal_clr),
        .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // returns {result, Z, C, V, N}
    function automatic logic [7:0] alu_ref(input logic [3:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            4'd0: begin
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1, 4'd4: begin
                r = a - b;
                c = (a < b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2, 4'd8: r = a & b;
            4'd3, 4'd9: r = a | b;
            4'd10: r = a ^ b;
            4'd11: r = ~a;
            4'd12: r = a << 1;
            4'd13: r = a >> 1;
            4'd14: r = b;
            4'd15: r = a + 4'd1;
            default: r = a ^ b ^ op;
        endcase
        return {r, (r == 4'd0), c, v, r[3]};
    endfunction

    assign {alu_result, alu_zero, alu_carry, alu_overflow, alu_negative} =
        alu_ref(alu_opcode, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sweep_rf(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check(tag, dbg_data, ref_rf[i]);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic use_imm, input logic [3:0] imm,
                         input logic clr, input logic hold);
        logic [3:0] a, b;
        logic [7:0] r;
        int w;
        w = 0;
        while (!in_ready && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready_wait", in_ready, 1);
        in_opcode  = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_valid   = 1'b1;
        a = ref_rf[rs1];
        b = use_imm ? imm : ref_rf[rs2];
        r = alu_ref(op, a, b);
        @(posedge clk); #1;
        if (hold) begin
            in_opcode = ~op;
            in_rs1    = ~rs1;
            in_imm    = ~imm;
            in_rd     = ~rd;
        end else begin
            in_valid = 1'b0;
        end
        check("exec_ready", in_ready, 0);
        check("exec_done", done, 0);
        @(posedge clk); #1;
        check("wb_done", done, 1);
        check("wb_ready", in_ready, 0);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_op", alu_opcode, op);
        dbg_addr = rd;
        #1;
        check("wb_dbg_old", dbg_data, ref_rf[rd]);
        illegal_clr = clr;
        @(posedge clk); #1;
        illegal_clr = 1'b0;
        in_valid    = 1'b0;
        if (op == 4'b0100) begin
            ref_flags = r[3:0];
        end else if (op >= 4'd5 && op <= 4'd7) begin
            ref_ill = 1'b1;
        end else begin
            ref_rf[rd] = r[7:4];
            ref_flags  = r[3:0];
        end
        if (!(op >= 4'd5 && op <= 4'd7) && clr) ref_ill = 1'b0;
        check("ret_done", done, 0);
        check("ret_ready", in_ready, 1);
        check("flags", flags, ref_flags);
        check("illegal", illegal, ref_ill);
        check("hold_op", alu_opcode, op);
        check("hold_a", alu_a, a);
        sweep_rf("rf");
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_opcode   = '0;
        in_rd       = '0;
        in_rs1      = '0;
        in_rs2      = '0;
        in_use_imm  = 1'b0;
        in_imm      = '0;
        illegal_clr = 1'b0;
        dbg_addr    = '0;
        for (int i = 0; i < 4; i++) ref_rf[i] = '0;
        ref_flags = '0;
        ref_ill   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", in_ready, 1);
        check("rst_done", done, 0);
        check("rst_flags", flags, 0);
        check("rst_ill", illegal, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_opcode, 0);
        sweep_rf("rst_rf");

        // directed sequence
        issue(4'b1001, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5, 1'b0, 1'b0);
        check("or_r1", ref_rf[1], 4'd5);
        issue(4'b0000, 2'd2, 2'd1, 2'd0, 1'b1, 4'd3, 1'b0, 1'b1);
        check("add_flags", flags, 4'b0011);
        issue(4'b0100, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        check("cmp_flags", flags, 4'b1000);
        issue(4'b0110, 2'd1, 2'd2, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        issue(4'b0101, 2'd0, 2'd2, 2'd1, 1'b0, 4'd0, 1'b1, 1'b0);
        illegal_clr = 1'b1;
        @(posedge clk); #1;
        illegal_clr = 1'b0;
        ref_ill = 1'b0;
        check("ill_clr", illegal, 0);

        // reset while in EXEC
        in_opcode  = 4'b0000;
        in_rd      = 2'd3;
        in_rs1     = 2'd1;
        in_use_imm = 1'b1;
        in_imm     = 4'd1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) ref_rf[i] = '0;
        ref_flags = '0;
        ref_ill   = 1'b0;
        check("mrst_ready", in_ready, 1);
        check("mrst_done", done, 0);
        check("mrst_alu_a", alu_a, 0);
        check("mrst_alu_b", alu_b, 0);
        check("mrst_alu_op", alu_opcode, 0);
        sweep_rf("mrst_rf");
        @(posedge clk); #1;
        check("mrst_done2", done, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            issue(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom),
                  2'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
